// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types: word and condition-code types, writeback
// FSM states, regfile mux selects and a select-legality helper.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [2:0]  lc3b_nzp;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HOLD  = 2'd1,
    READY = 2'd2
  } wb_state_t;

  localparam logic [2:0] WB_SEL_DATA = 3'd0;
  localparam logic [2:0] WB_SEL_PC   = 3'd1;

  // Condition codes after reset: the architectural "zero" state.
  localparam lc3b_nzp NZP_RESET = 3'b010;

  // Only the data and PC mux inputs exist; every other select is reserved.
  function automatic logic wb_sel_legal(input logic [2:0] sel);
    return (sel == WB_SEL_DATA) || (sel == WB_SEL_PC);
  endfunction

endpackage

// File: rtl/cc_gen.sv
// Condition-code generator: maps a 16-bit word to one-hot {n,z,p}.
// Purely combinational so any stage can reuse it.
module cc_gen
  import lc3b_types::*;
(
  input  logic [15:0] value,
  output lc3b_nzp     cc
);

  // Negative takes priority via the sign bit, then zero, else positive.
  always_comb begin
    cc = 3'b000;
    if (value[15]) begin
      cc = 3'b100;
    end else if (value == 16'h0000) begin
      cc = 3'b010;
    end else begin
      cc = 3'b001;
    end
  end

endmodule

// File: rtl/writeback_unit.sv
// LC-3b writeback stage. Accepts one retiring instruction per handshake,
// waits in HOLD for a late data-memory response on loads, and presents the
// committing entry on the regfile write port for exactly one READY cycle.
// Optional build macro: WB_CC_BYPASS_EN forwards the freshly computed NZP
// combinationally during the commit cycle; without it nzp is the register.
module writeback_unit
  import lc3b_types::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_valid,
  output logic        wb_ready,
  input  logic [15:0] mem_ir,
  input  logic [15:0] mem_pc,
  input  logic [15:0] mem_alu,
  input  logic        mem_is_load,
  input  logic        mem_load_reg,
  input  logic        mem_load_cc,
  input  logic        mem_dest_r7,
  input  logic [2:0]  mem_wb_sel,
  input  logic        dmem_resp,
  input  logic [15:0] dmem_rdata,
  output logic        regfile_load,
  output logic [2:0]  wb_mux_sel,
  output logic        wb_dest_sel,
  output logic [15:0] wb_data,
  output logic [15:0] wb_pc,
  output logic [15:0] wb_ir,
  output logic [2:0]  nzp,
  output logic        wb_err
);

  wb_state_t state_q, state_d;

  // Pending load fields, held while waiting for the data-memory response.
  logic [15:0] pend_ir_q, pend_ir_d;
  logic [15:0] pend_pc_q, pend_pc_d;
  logic        pend_load_reg_q, pend_load_reg_d;
  logic        pend_load_cc_q, pend_load_cc_d;
  logic        pend_dest_r7_q, pend_dest_r7_d;
  logic [2:0]  pend_wb_sel_q, pend_wb_sel_d;

  // Committing entry; doubles as the registered regfile-port outputs so the
  // port holds its last values between commits.
  logic        regfile_load_q, regfile_load_d;
  logic [2:0]  wb_mux_sel_q, wb_mux_sel_d;
  logic        wb_dest_sel_q, wb_dest_sel_d;
  logic [15:0] wb_data_q, wb_data_d;
  logic [15:0] wb_pc_q, wb_pc_d;
  logic [15:0] wb_ir_q, wb_ir_d;
  logic        load_cc_q, load_cc_d;

  lc3b_nzp     nzp_q, nzp_d;
  logic        wb_err_q, wb_err_d;

  logic        xfer_s;
  logic        commit_legal_s;
  logic        commit_cc_en_s;
  logic [15:0] commit_value_s;
  lc3b_nzp     commit_cc_s;

  assign wb_ready = (state_q != HOLD);
  assign xfer_s   = mem_valid & wb_ready;

  // Next-state, capture and commit-entry selection for the writeback FSM.
  always_comb begin
    state_d         = state_q;
    pend_ir_d       = pend_ir_q;
    pend_pc_d       = pend_pc_q;
    pend_load_reg_d = pend_load_reg_q;
    pend_load_cc_d  = pend_load_cc_q;
    pend_dest_r7_d  = pend_dest_r7_q;
    pend_wb_sel_d   = pend_wb_sel_q;
    regfile_load_d  = 1'b0;
    wb_mux_sel_d    = wb_mux_sel_q;
    wb_dest_sel_d   = wb_dest_sel_q;
    wb_data_d       = wb_data_q;
    wb_pc_d         = wb_pc_q;
    wb_ir_d         = wb_ir_q;
    load_cc_d       = load_cc_q;

    case (state_q)
      EMPTY, READY: begin
        if (xfer_s) begin
          pend_ir_d       = mem_ir;
          pend_pc_d       = mem_pc;
          pend_load_reg_d = mem_load_reg;
          pend_load_cc_d  = mem_load_cc;
          pend_dest_r7_d  = mem_dest_r7;
          pend_wb_sel_d   = mem_wb_sel;
          if (!mem_is_load || dmem_resp) begin
            state_d        = READY;
            regfile_load_d = mem_load_reg & wb_sel_legal(mem_wb_sel);
            wb_mux_sel_d   = mem_wb_sel;
            wb_dest_sel_d  = mem_dest_r7;
            wb_data_d      = mem_is_load ? dmem_rdata : mem_alu;
            wb_pc_d        = mem_pc;
            wb_ir_d        = mem_ir;
            load_cc_d      = mem_load_cc;
          end else begin
            state_d = HOLD;
          end
        end else begin
          state_d = EMPTY;
        end
      end
      HOLD: begin
        if (dmem_resp) begin
          state_d        = READY;
          regfile_load_d = pend_load_reg_q & wb_sel_legal(pend_wb_sel_q);
          wb_mux_sel_d   = pend_wb_sel_q;
          wb_dest_sel_d  = pend_dest_r7_q;
          wb_data_d      = dmem_rdata;
          wb_pc_d        = pend_pc_q;
          wb_ir_d        = pend_ir_q;
          load_cc_d      = pend_load_cc_q;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  assign commit_legal_s = wb_sel_legal(wb_mux_sel_q);
  assign commit_value_s = (wb_mux_sel_q == WB_SEL_PC) ? wb_pc_q : wb_data_q;
  assign commit_cc_en_s = (state_q == READY) & load_cc_q & commit_legal_s;

  cc_gen u_cc_gen (
    .value (commit_value_s),
    .cc    (commit_cc_s)
  );

  // Condition-code and sticky-error updates at the end of a commit cycle.
  always_comb begin
    nzp_d    = nzp_q;
    wb_err_d = wb_err_q;
    if (commit_cc_en_s) begin
      nzp_d = commit_cc_s;
    end else begin
      nzp_d = nzp_q;
    end
    if ((state_q == READY) && !commit_legal_s) begin
      wb_err_d = 1'b1;
    end else begin
      wb_err_d = wb_err_q;
    end
  end

  // State, pending entry, commit entry and architectural CC registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= EMPTY;
      pend_ir_q       <= 16'h0000;
      pend_pc_q       <= 16'h0000;
      pend_load_reg_q <= 1'b0;
      pend_load_cc_q  <= 1'b0;
      pend_dest_r7_q  <= 1'b0;
      pend_wb_sel_q   <= 3'd0;
      regfile_load_q  <= 1'b0;
      wb_mux_sel_q    <= 3'd0;
      wb_dest_sel_q   <= 1'b0;
      wb_data_q       <= 16'h0000;
      wb_pc_q         <= 16'h0000;
      wb_ir_q         <= 16'h0000;
      load_cc_q       <= 1'b0;
      nzp_q           <= NZP_RESET;
      wb_err_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      pend_ir_q       <= pend_ir_d;
      pend_pc_q       <= pend_pc_d;
      pend_load_reg_q <= pend_load_reg_d;
      pend_load_cc_q  <= pend_load_cc_d;
      pend_dest_r7_q  <= pend_dest_r7_d;
      pend_wb_sel_q   <= pend_wb_sel_d;
      regfile_load_q  <= regfile_load_d;
      wb_mux_sel_q    <= wb_mux_sel_d;
      wb_dest_sel_q   <= wb_dest_sel_d;
      wb_data_q       <= wb_data_d;
      wb_pc_q         <= wb_pc_d;
      wb_ir_q         <= wb_ir_d;
      load_cc_q       <= load_cc_d;
      nzp_q           <= nzp_d;
      wb_err_q        <= wb_err_d;
    end
  end

  assign regfile_load = regfile_load_q;
  assign wb_mux_sel   = wb_mux_sel_q;
  assign wb_dest_sel  = wb_dest_sel_q;
  assign wb_data      = wb_data_q;
  assign wb_pc        = wb_pc_q;
  assign wb_ir        = wb_ir_q;
  assign wb_err       = wb_err_q;

`ifdef WB_CC_BYPASS_EN
  // A branch in decode sees the new CC already in the commit cycle.
  assign nzp = commit_cc_en_s ? commit_cc_s : nzp_q;
`else
  assign nzp = nzp_q;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: stimulus pushes expected commits,
// a negedge monitor pops and compares whenever regfile_load is seen.
module tb_writeback_unit;

`ifdef WB_CC_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mem_valid;
  logic        wb_ready;
  logic [15:0] mem_ir, mem_pc, mem_alu;
  logic        mem_is_load, mem_load_reg, mem_load_cc, mem_dest_r7;
  logic [2:0]  mem_wb_sel;
  logic        dmem_resp;
  logic [15:0] dmem_rdata;
  logic        regfile_load;
  logic [2:0]  wb_mux_sel;
  logic        wb_dest_sel;
  logic [15:0] wb_data, wb_pc, wb_ir;
  logic [2:0]  nzp;
  logic        wb_err;

  int checks = 0;
  int errors = 0;
  int commits = 0;
  int base;

  typedef struct packed {
    logic [2:0]  mux;
    logic        dest;
    logic [15:0] data;
    logic [15:0] pc;
    logic [15:0] ir;
  } exp_t;

  exp_t exp_q[$];

  writeback_unit dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .mem_valid    (mem_valid),
    .wb_ready     (wb_ready),
    .mem_ir       (mem_ir),
    .mem_pc       (mem_pc),
    .mem_alu      (mem_alu),
    .mem_is_load  (mem_is_load),
    .mem_load_reg (mem_load_reg),
    .mem_load_cc  (mem_load_cc),
    .mem_dest_r7  (mem_dest_r7),
    .mem_wb_sel   (mem_wb_sel),
    .dmem_resp    (dmem_resp),
    .dmem_rdata   (dmem_rdata),
    .regfile_load (regfile_load),
    .wb_mux_sel   (wb_mux_sel),
    .wb_dest_sel  (wb_dest_sel),
    .wb_data      (wb_data),
    .wb_pc        (wb_pc),
    .wb_ir        (wb_ir),
    .nzp          (nzp),
    .wb_err       (wb_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Present one instruction (valid stays high until the caller drops it).
  task automatic drive(input logic [15:0] ir, input logic [15:0] pc, input logic [15:0] alu,
                       input logic is_load, input logic lr, input logic lcc, input logic dest,
                       input logic [2:0] sel, input logic resp, input logic [15:0] rdata,
                       input logic push, input logic [15:0] exp_data);
    exp_t e;
    mem_valid    = 1'b1;
    mem_ir       = ir;
    mem_pc       = pc;
    mem_alu      = alu;
    mem_is_load  = is_load;
    mem_load_reg = lr;
    mem_load_cc  = lcc;
    mem_dest_r7  = dest;
    mem_wb_sel   = sel;
    dmem_resp    = resp;
    dmem_rdata   = rdata;
    if (push) begin
      e.mux  = sel;
      e.dest = dest;
      e.data = exp_data;
      e.pc   = pc;
      e.ir   = ir;
      exp_q.push_back(e);
    end
  endtask

  task automatic issue(input logic [15:0] ir, input logic [15:0] pc, input logic [15:0] alu,
                       input logic is_load, input logic lr, input logic lcc, input logic dest,
                       input logic [2:0] sel, input logic resp, input logic [15:0] rdata,
                       input logic push, input logic [15:0] exp_data);
    drive(ir, pc, alu, is_load, lr, lcc, dest, sel, resp, rdata, push, exp_data);
    @(posedge clk);
    #1;
    mem_valid = 1'b0;
    dmem_resp = 1'b0;
  endtask

  // Monitor: every regfile write must match the oldest expected commit.
  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    if (reset_n === 1'b1 && regfile_load === 1'b1) begin
      checks++;
      commits++;
      a = {wb_mux_sel, wb_dest_sel, wb_data, wb_pc, wb_ir};
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL commit: unexpected regfile_load got %h expected none", a);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL commit: got %h expected %h", a, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; mem_valid = 1'b0; mem_ir = 16'h0; mem_pc = 16'h0; mem_alu = 16'h0;
    mem_is_load = 1'b0; mem_load_reg = 1'b0; mem_load_cc = 1'b0; mem_dest_r7 = 1'b0;
    mem_wb_sel = 3'd0; dmem_resp = 1'b0; dmem_rdata = 16'h0;
    repeat (2) @(negedge clk);
    check("rst_regfile_load", {15'd0, regfile_load}, 16'h0000);
    check("rst_wb_ready", {15'd0, wb_ready}, 16'h0001);
    check("rst_nzp", {13'd0, nzp}, 16'h0002);
    check("rst_wb_err", {15'd0, wb_err}, 16'h0000);
    check("rst_wb_data", wb_data, 16'h0000);
    check("rst_wb_mux_sel", {13'd0, wb_mux_sel}, 16'h0000);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // ADD producing a negative result.
    issue(16'h1042, 16'h3001, 16'h8000, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 16'h0, 1'b1, 16'h8000);
    @(negedge clk);
    check("add_regfile_load", {15'd0, regfile_load}, 16'h0001);
    check("add_nzp_commit_cycle", {13'd0, nzp}, BYP ? 16'h0004 : 16'h0002);
    @(posedge clk); #1;
    check("add_nzp_after", {13'd0, nzp}, 16'h0004);

    // LDR with the response three cycles after the transfer.
    issue(16'h6283, 16'h3002, 16'h4000, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 16'hFFFF, 1'b1, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        dmem_resp = 1'b1;
        dmem_rdata = 16'h0000;
      end
      @(negedge clk);
      check("ldr_wb_ready_hold", {15'd0, wb_ready}, 16'h0000);
      @(posedge clk); #1;
      dmem_resp = 1'b0;
    end
    @(negedge clk);
    check("ldr_regfile_load", {15'd0, regfile_load}, 16'h0001);
    check("ldr_nzp_commit_cycle", {13'd0, nzp}, BYP ? 16'h0002 : 16'h0004);
    @(posedge clk); #1;
    check("ldr_nzp_after", {13'd0, nzp}, 16'h0002);
    check("ldr_wb_ready_after", {15'd0, wb_ready}, 16'h0001);

    // JSR: link PC into R7, CC untouched.
    issue(16'h4802, 16'h3002, 16'h1234, 1'b0, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0, 16'h0, 1'b1, 16'h1234);
    @(negedge clk);
    check("jsr_regfile_load", {15'd0, regfile_load}, 16'h0001);
    @(posedge clk); #1;
    check("jsr_nzp_unchanged", {13'd0, nzp}, 16'h0002);

    // Four back-to-back ALU ops.
    base = commits;
    for (int i = 0; i < 4; i++) begin
      drive(16'h1000 + 16'(i), 16'h3010 + 16'(i), 16'(i + 1), 1'b0, 1'b1, 1'b1, 1'b0, 3'd0,
            1'b0, 16'h0, 1'b1, 16'(i + 1));
      @(negedge clk);
      check("b2b_wb_ready", {15'd0, wb_ready}, 16'h0001);
      if (i > 0) check("b2b_regfile_load", {15'd0, regfile_load}, 16'h0001);
      @(posedge clk); #1;
    end
    mem_valid = 1'b0;
    @(negedge clk);
    check("b2b_last_regfile_load", {15'd0, regfile_load}, 16'h0001);
    @(posedge clk); #1;
    check("b2b_commit_count", 16'(commits - base), 16'h0004);
    check("b2b_nzp", {13'd0, nzp}, 16'h0001);

    // Stray response while empty must be ignored.
    dmem_resp = 1'b1; dmem_rdata = 16'h8000;
    @(posedge clk); #1;
    dmem_resp = 1'b0;
    @(negedge clk);
    check("stray_resp_no_load", {15'd0, regfile_load}, 16'h0000);
    @(posedge clk); #1;

    // Load with a same-cycle response behaves like a non-load.
    issue(16'h6000, 16'h3020, 16'h0011, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 16'h8000, 1'b1, 16'h8000);
    @(negedge clk);
    check("ld_same_regfile_load", {15'd0, regfile_load}, 16'h0001);
    @(posedge clk); #1;
    check("ld_same_nzp", {13'd0, nzp}, 16'h0004);

    // Reserved select: no write, no CC update, sticky error.
    issue(16'h1111, 16'h3030, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 3'd5, 1'b0, 16'h0, 1'b0, 16'h0);
    @(negedge clk);
    check("rsv_no_regfile_load", {15'd0, regfile_load}, 16'h0000);
    @(posedge clk); #1;
    @(negedge clk);
    check("rsv_wb_err", {15'd0, wb_err}, 16'h0001);
    check("rsv_nzp_kept", {13'd0, nzp}, 16'h0004);
    issue(16'h1222, 16'h3031, 16'h0005, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 16'h0, 1'b1, 16'h0005);
    repeat (3) @(negedge clk);
    check("rsv_wb_err_sticky", {15'd0, wb_err}, 16'h0001);
    @(posedge clk); #1;

    // Reset while a load is held; a late response afterwards is ignored.
    issue(16'h6444, 16'h3040, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 16'h0, 1'b0, 16'h0);
    @(negedge clk);
    check("hold_before_reset", {15'd0, wb_ready}, 16'h0000);
    reset_n = 1'b0;
    #1;
    check("mid_rst_wb_ready", {15'd0, wb_ready}, 16'h0001);
    check("mid_rst_nzp", {13'd0, nzp}, 16'h0002);
    check("mid_rst_wb_err", {15'd0, wb_err}, 16'h0000);
    check("mid_rst_wb_data", wb_data, 16'h0000);
    check("mid_rst_wb_pc", wb_pc, 16'h0000);
    check("mid_rst_wb_ir", wb_ir, 16'h0000);
    check("mid_rst_dest", {15'd0, wb_dest_sel}, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    dmem_resp = 1'b1; dmem_rdata = 16'h1234;
    @(posedge clk); #1;
    dmem_resp = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("late_resp_no_load", {15'd0, regfile_load}, 16'h0000);
    end
    check("late_resp_wb_ready", {15'd0, wb_ready}, 16'h0001);
    check("late_resp_nzp", {13'd0, nzp}, 16'h0002);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 16'(exp_q.size()), 16'h0000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
# writeback_unit

LC-3b pipeline writeback stage: accepts one retiring instruction per handshake from the memory stage, waits for a multi-cycle data-memory response on loads, and drives the register-file write port of the decode stage (`regfile_load`, `wb_mux_sel`, `wb_dest_sel`, `wb_data`, `wb_pc`, `wb_ir`). It also holds the architectural NZP condition codes for branch resolution. It is the producer side of the decode stage's regfile write interface.

## Interface
- No parameters; widths come from `lc3b_types`.
- `clk` in 1: single clock, all state on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `mem_valid` in 1: memory stage presents an instruction.
- `wb_ready` out 1: unit can accept; a transfer happens when `mem_valid & wb_ready`.
- `mem_ir` in 16: instruction word.
- `mem_pc` in 16: incremented PC of the instruction, used for R7 link.
- `mem_alu` in 16: ALU/address result.
- `mem_is_load` in 1: result comes from data memory.
- `mem_load_reg` in 1: instruction writes a register.
- `mem_load_cc` in 1: instruction updates NZP.
- `mem_dest_r7` in 1: destination is R7, not IR[11:9].
- `mem_wb_sel` in 3: regfile mux select (0 = data, 1 = PC, 2–7 reserved).
- `dmem_resp` in 1: data-memory read response strobe.
- `dmem_rdata` in 16: read data, valid when `dmem_resp`.
- `regfile_load` out 1: regfile write enable.
- `wb_mux_sel` out 3: regfile input mux select.
- `wb_dest_sel` out 1: 1 = R7.
- `wb_data` out 16: data word (load data or ALU result).
- `wb_pc` out 16: link PC.
- `wb_ir` out 16: committing instruction word.
- `nzp` out 3: condition codes {n,z,p}.
- `wb_err` out 1: sticky flag set on a reserved `mem_wb_sel`.

## Operation
- States: EMPTY, HOLD, READY.
- `wb_ready` = 1 in EMPTY and READY; 0 in HOLD.
- The unit captures on transfer: `ir`, `pc`, `alu`, control bits.
  - If the instruction is not a load, or is a load with `dmem_resp` in the same cycle: data = `mem_is_load ? dmem_rdata : mem_alu`; next state READY.
  - If it is a load without `dmem_resp`: next state HOLD.
- If there is no transfer in EMPTY or READY, next state is EMPTY.
- In HOLD, `dmem_resp` latches `dmem_rdata` into data and moves to READY. Otherwise the unit stays in HOLD.
- `dmem_resp` outside HOLD and outside a load transfer is ignored.
- Commit happens in the READY cycle:
  - `regfile_load = mem_load_reg` (captured) AND `wb_sel` ∈ {0,1}.
  - The outputs `wb_mux_sel`, `wb_dest_sel`, `wb_data`, `wb_pc` and `wb_ir` reflect the entry.
- Commit value: `wb_sel == 1 ? pc : data`.
  - If `load_cc` is set, `nzp` takes n = value[15], z = (value == 0), p = otherwise. Exactly one bit is set.
- A reserved `wb_sel` suppresses the regfile write and the CC update, and sets `wb_err` until reset.
- READY with a new transfer in the same cycle: the old entry commits and the new entry is captured at the same edge, giving back-to-back commits with no bubble.
- Outside READY, `regfile_load = 0`; the other outputs hold their last values.

## Timing
- Non-load latency: transfer at edge N, `regfile_load` is high for cycle N→N+1, and the regfile writes at edge N+1.
- Load latency: `dmem_resp` at edge M (in HOLD) leads to a write at edge M+1. A same-cycle response behaves as a non-load.
- Throughput: 1 instruction/cycle when there are no loads waiting.
- Reset (any time, including in HOLD):
  - state EMPTY, entry dropped.
  - `regfile_load` = 0, `wb_mux_sel` = 0, `wb_dest_sel` = 0.
  - `wb_data`, `wb_pc`, `wb_ir` = 16'h0000.
  - `nzp` = 3'b010, `wb_err` = 0, `wb_ready` = 1 while `reset_n` is low.
  - A late `dmem_resp` after reset is ignored.

## Configuration
- `WB_CC_BYPASS_EN` defined:
  - `nzp` output = computed CC during a READY cycle with `load_cc` and a legal select, combinationally.
  - Otherwise `nzp` = the register.
  - A branch in decode sees the new CC in the commit cycle.
- Not defined: `nzp` is the register only and reflects the commit from edge N+1 onward.
- The register update is identical in both builds.

## Structure
- Put these in `lc3b_types`:
  - `lc3b_nzp` (3-bit).
  - `wb_state_t` enum {EMPTY, HOLD, READY}.
  - constants `WB_SEL_DATA = 3'd0` and `WB_SEL_PC = 3'd1`.
- Sub-module `cc_gen`: combinational 16-bit word → `lc3b_nzp`, reusable by other stages.

## Test plan
- Reset, then an ADD with `mem_alu` = 16'h8000, load_reg = 1, load_cc = 1 → next cycle `regfile_load` = 1, `wb_data` = 16'h8000; after the edge, `nzp` = 3'b100.
- LDR with `dmem_resp` 3 cycles later and `dmem_rdata` = 16'h0000 → `wb_ready` = 0 for 3 cycles, then one commit cycle with `wb_data` = 0; `nzp` becomes 3'b010.
- JSR with `mem_pc` = 16'h3002, dest_r7 = 1, wb_sel = 1 → `wb_dest_sel` = 1, `wb_mux_sel` = 1, `wb_pc` = 16'h3002, NZP unchanged.
- Four back-to-back ALU ops with values 1, 2, 3, 4 → four consecutive `regfile_load` cycles with matching `wb_data`, and `wb_ready` held at 1.
- `reset_n` low during HOLD, then `dmem_resp` pulsed after release → no `regfile_load`, state EMPTY, `nzp` = 3'b010.
- `mem_wb_sel` = 5 with load_reg = 1 → no `regfile_load`, `wb_err` = 1 and sticky; with and without `WB_CC_BYPASS_EN`, the CC timing of the first scenario differs by exactly one cycle.
